// File: rtl/blink_pkg.sv
// blink_pkg: shared clock constants and the prescaler width helper for the blinker.
package blink_pkg;
    localparam int CLK_HZ           = 25_000_000;
    localparam int DEFAULT_TICK_DIV = CLK_HZ / 2;
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen
    import blink_pkg::*;
#(
    parameter int TICK_DIV = blink_pkg::DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = cnt_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] r_div_cnt;
    // With TICK_DIV == 1, LAST is 0 so the counter parks at 0 and tick stays high.
    assign tick = (r_div_cnt == LAST);
    always_ff @(posedge clk) begin
        if (!rst_n) r_div_cnt <= '0;
        else        r_div_cnt <= tick ? '0 : r_div_cnt + W'(1);
    end
endmodule

// File: rtl/blink_top.sv
// blink_top: LED blinker; a free-running pattern counter advanced by the prescaler tick.
module blink_top
    import blink_pkg::*;
#(
    parameter int LED_W    = 4,
    parameter int TICK_DIV = blink_pkg::DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [LED_W-1:0] led
);
    logic             w_tick;
    logic [LED_W-1:0] r_led;
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );
    always_ff @(posedge clk) begin
        if (!rst_n)      r_led <= '0;
        else if (w_tick) r_led <= r_led + LED_W'(1);
    end
    assign led = r_led;
endmodule

// File: tb/tb_blink_top.sv
// tb_blink_top: checks five blinker instances (TICK_DIV 1..5) against an edge-count model.
module tb_blink_top;
    logic       clk;
    logic [4:0] rst_n_v;
    logic [3:0] led_v [5];
    int         div_v [5];
    int         k [5];
    int         checks, failures;

    typedef struct {
        logic rst_n;
        int   exp_led;
        int   exp_div;
    } vec_t;
    vec_t tbl [23];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        blink_top #(.LED_W(4), .TICK_DIV(g + 1)) u_dut (
            .clk   (clk),
            .rst_n (rst_n_v[g]),
            .led   (led_v[g])
        );
        assign div_v[g] = int'(u_dut.u_tick.r_div_cnt);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Model: k counts edges since the last edge that sampled reset low.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 5; i++) k[i] = rst_n_v[i] ? k[i] + 1 : 0;
        #1;
    endtask

    task automatic check_all();
        for (int i = 0; i < 5; i++) begin
            cmp($sformatf("led_td%0d_k%0d", i + 1, k[i]), int'(led_v[i]), (k[i] / (i + 1)) % 16);
            cmp($sformatf("div_td%0d_k%0d", i + 1, k[i]), div_v[i], k[i] % (i + 1));
        end
    endtask

    initial begin
        int last0, last3, n0, n3;
        logic [3:0] prev;
        checks = 0;
        failures = 0;
        rst_n_v = '0;
        for (int i = 0; i < 5; i++) k[i] = 0;
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 0, 0};
        for (int e = 1; e <= 20; e++) tbl[e + 2] = '{1'b1, (e / 2) % 16, e % 2};

        // Reset, count sequence (TD=2) and 17-edge wrap (TD=1) share this run.
        for (int i = 0; i < 23; i++) begin
            rst_n_v = {5{tbl[i].rst_n}};
            step();
            cmp($sformatf("tbl_led_%0d", i), int'(led_v[1]), tbl[i].exp_led);
            cmp($sformatf("tbl_div_%0d", i), div_v[1], tbl[i].exp_div);
            check_all();
        end
        cmp("wrap_td1_after20", int'(led_v[0]), 4);

        // Mid-operation reset on TD=3 and reset-during-tick on TD=4.
        rst_n_v = '0;
        step();
        rst_n_v = '1;
        for (int i = 0; i < 7; i++) step();
        cmp("mid_led_before", int'(led_v[2]), 2);
        cmp("mid_div_before", div_v[2], 1);
        cmp("prio_div_before", div_v[3], 3);
        cmp("prio_led_before", int'(led_v[3]), 1);
        rst_n_v[2] = 1'b0;
        rst_n_v[3] = 1'b0;
        step();
        cmp("mid_led_rst", int'(led_v[2]), 0);
        cmp("mid_div_rst", div_v[2], 0);
        cmp("prio_led_rst", int'(led_v[3]), 0);
        cmp("prio_div_rst", div_v[3], 0);
        rst_n_v = '1;
        step();
        cmp("mid_led_e1", int'(led_v[2]), 0);
        step();
        cmp("mid_led_e2", int'(led_v[2]), 0);
        step();
        cmp("mid_led_e3", int'(led_v[2]), 1);
        check_all();

        // Bit rates on TD=5 measured by edge counting.
        rst_n_v = '0;
        step();
        rst_n_v = '1;
        prev = led_v[4];
        last0 = 0;
        last3 = 0;
        n0 = 0;
        n3 = 0;
        for (int e = 1; e <= 200; e++) begin
            step();
            if (led_v[4][0] != prev[0]) begin
                n0++;
                if (e - last0 != 5) cmp($sformatf("bit0_period_e%0d", e), e - last0, 5);
                last0 = e;
            end
            if (led_v[4][3] != prev[3]) begin
                n3++;
                cmp($sformatf("bit3_period_e%0d", e), e - last3, 40);
                last3 = e;
            end
            prev = led_v[4];
        end
        cmp("bit0_toggles", n0, 40);
        cmp("bit3_toggles", n3, 5);
        check_all();

        // Random independent resets against the model.
        for (int e = 0; e < 400; e++) begin
            for (int i = 0; i < 5; i++) rst_n_v[i] = ($urandom_range(0, 15) != 0);
            step();
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
